// File: rtl/bcpu_regfile_pkg.sv
// Shared types, defaults and helpers for the multithreaded BCPU register file.
package bcpu_regfile_pkg;

  localparam int unsigned DEF_DATA_WIDTH  = 16;
  localparam int unsigned DEF_REG_BITS    = 3;
  localparam int unsigned DEF_THREAD_BITS = 2;
  localparam int unsigned DEF_RD_PORTS    = 2;
  localparam int unsigned DEF_BYPASS      = 1;
  localparam int unsigned DEF_ZERO_R0     = 0;

  // INIT sweeps the whole array, TCLR sweeps one thread's registers.
  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_TCLR = 2'd2
  } state_t;

  // Address is {thread, reg}.
  function automatic int unsigned addr_w(input int unsigned thread_bits,
                                         input int unsigned reg_bits);
    return thread_bits + reg_bits;
  endfunction

endpackage

// File: rtl/bcpu_regfile_ram.sv
// Register storage: one synchronous write port, RD_PORTS combinational read ports, no reset.
module bcpu_regfile_ram #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned RD_PORTS   = 2
) (
  input  logic                           clk,
  input  logic                           we,
  input  logic [ADDR_W-1:0]              waddr,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic [RD_PORTS*ADDR_W-1:0]     raddr,
  output logic [RD_PORTS*DATA_WIDTH-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  for (genvar i = 0; i < RD_PORTS; i++) begin : g_rd
    assign rdata[i*DATA_WIDTH +: DATA_WIDTH] = mem[raddr[i*ADDR_W +: ADDR_W]];
  end

endmodule

// File: rtl/bcpu_regfile_mt.sv
// Multithreaded register file with power-up zero sweep, per-thread clear,
// optional write-to-read forwarding and optional hardwired-zero register 0.
module bcpu_regfile_mt
  import bcpu_regfile_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int unsigned REG_BITS    = DEF_REG_BITS,
  parameter int unsigned THREAD_BITS = DEF_THREAD_BITS,
  parameter int unsigned RD_PORTS    = DEF_RD_PORTS,
  parameter int unsigned BYPASS      = DEF_BYPASS,
  parameter int unsigned ZERO_R0     = DEF_ZERO_R0
) (
  input  logic                                        clk,
  input  logic                                        reset_n,
  input  logic                                        reg_wr_en,
  input  logic [THREAD_BITS+REG_BITS-1:0]             wr_reg_addr,
  input  logic [DATA_WIDTH-1:0]                       wr_reg_data,
  input  logic [RD_PORTS*(THREAD_BITS+REG_BITS)-1:0]  rd_reg_addr,
  output logic [RD_PORTS*DATA_WIDTH-1:0]              rd_reg_data,
  input  logic                                        clr_req,
  input  logic [THREAD_BITS-1:0]                      clr_thread,
  output logic                                        clr_ack,
  output logic                                        ready,
  output logic                                        wr_drop
);

  localparam int unsigned ADDR_W = addr_w(THREAD_BITS, REG_BITS);
  localparam int unsigned DEPTH  = 1 << ADDR_W;
  localparam int unsigned REGS   = 1 << REG_BITS;

  localparam logic [ADDR_W-1:0] INIT_LAST = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] TCLR_LAST = ADDR_W'(REGS - 1);

  state_t                  state;
  logic [ADDR_W-1:0]       cnt;
  logic [THREAD_BITS-1:0]  thread_q;

  logic                    ram_we;
  logic [ADDR_W-1:0]       ram_waddr;
  logic [DATA_WIDTH-1:0]   ram_wdata;
  logic [RD_PORTS*DATA_WIDTH-1:0] ram_rdata;
  logic                    fwd_en;

  // Control FSM; terminal counts are compared explicitly so the counter never relies on wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_INIT;
      cnt      <= '0;
      thread_q <= '0;
      ready    <= 1'b0;
      clr_ack  <= 1'b0;
      wr_drop  <= 1'b0;
    end else begin
      clr_ack <= 1'b0;
      wr_drop <= reg_wr_en && (state != ST_IDLE);
      unique case (state)
        ST_INIT: begin
          if (cnt == INIT_LAST) begin
            state <= ST_IDLE;
            cnt   <= '0;
            ready <= 1'b1;
          end else begin
            cnt <= cnt + ADDR_W'(1);
          end
        end
        ST_IDLE: begin
          if (clr_req) begin
            state    <= ST_TCLR;
            thread_q <= clr_thread;
            cnt      <= '0;
            ready    <= 1'b0;
          end
        end
        ST_TCLR: begin
          if (cnt == TCLR_LAST) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            ready   <= 1'b1;
            clr_ack <= 1'b1;
          end else begin
            cnt <= cnt + ADDR_W'(1);
          end
        end
        default: begin
          state <= ST_INIT;
          cnt   <= '0;
          ready <= 1'b0;
        end
      endcase
    end
  end

  // Single RAM write port: external writes only in IDLE, otherwise the zero sweep owns it.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = cnt;
    ram_wdata = '0;
    unique case (state)
      ST_IDLE: begin
        ram_we    = reg_wr_en;
        ram_waddr = wr_reg_addr;
        ram_wdata = wr_reg_data;
      end
      ST_TCLR: begin
        ram_we    = 1'b1;
        ram_waddr = {thread_q, cnt[REG_BITS-1:0]};
      end
      default: begin
        ram_we = 1'b1;
      end
    endcase
  end

  bcpu_regfile_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_W     (ADDR_W),
    .RD_PORTS   (RD_PORTS)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (rd_reg_addr),
    .rdata (ram_rdata)
  );

  // Forwarding only when the write is actually performed this cycle.
  assign fwd_en = (BYPASS != 0) && (state == ST_IDLE) && reg_wr_en;

  // Zero masking of register 0 takes priority over forwarding.
  for (genvar i = 0; i < RD_PORTS; i++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              hit;
    logic              zero;

    assign ra   = rd_reg_addr[i*ADDR_W +: ADDR_W];
    assign hit  = fwd_en && (ra == wr_reg_addr);
    assign zero = (ZERO_R0 != 0) && (ra[REG_BITS-1:0] == '0);

    assign rd_reg_data[i*DATA_WIDTH +: DATA_WIDTH] =
      zero ? '0 : (hit ? wr_reg_data : ram_rdata[i*DATA_WIDTH +: DATA_WIDTH]);
  end

endmodule

// File: tb/tb_bcpu_regfile_mt.sv
// Scoreboard bench for bcpu_regfile_mt: two instances (ZERO_R0=0/1) share stimulus.
module tb_bcpu_regfile_mt;

  localparam int K_RDY  = 0;
  localparam int K_ACK  = 1;
  localparam int K_DROP = 2;
  localparam int K_RD0  = 3;
  localparam int K_RD1  = 4;
  localparam int NEVER  = 32'h7fff_ffff;

  logic        clk;
  logic        reset_n;
  logic        reg_wr_en;
  logic [4:0]  wr_reg_addr;
  logic [15:0] wr_reg_data;
  logic [9:0]  rd_reg_addr;
  logic        clr_req;
  logic [1:0]  clr_thread;

  logic [31:0] rdd0, rdd1;
  logic        ack0, ack1, rdy0, rdy1, drop0, drop1;

  bcpu_regfile_mt #(
    .DATA_WIDTH(16), .REG_BITS(3), .THREAD_BITS(2), .RD_PORTS(2), .BYPASS(1), .ZERO_R0(0)
  ) dut0 (
    .clk(clk), .reset_n(reset_n), .reg_wr_en(reg_wr_en), .wr_reg_addr(wr_reg_addr),
    .wr_reg_data(wr_reg_data), .rd_reg_addr(rd_reg_addr), .rd_reg_data(rdd0),
    .clr_req(clr_req), .clr_thread(clr_thread), .clr_ack(ack0), .ready(rdy0), .wr_drop(drop0)
  );

  bcpu_regfile_mt #(
    .DATA_WIDTH(16), .REG_BITS(3), .THREAD_BITS(2), .RD_PORTS(2), .BYPASS(1), .ZERO_R0(1)
  ) dut1 (
    .clk(clk), .reset_n(reset_n), .reg_wr_en(reg_wr_en), .wr_reg_addr(wr_reg_addr),
    .wr_reg_data(wr_reg_data), .rd_reg_addr(rd_reg_addr), .rd_reg_data(rdd1),
    .clr_req(clr_req), .clr_thread(clr_thread), .clr_ack(ack1), .ready(rdy1), .wr_drop(drop1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  typedef struct {
    int          cyc;
    int          kind;
    int          inst;
    logic [15:0] exp;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: register contents plus a timeline of when the file is busy.
  logic [15:0] mem [32];
  bit          in_reset    = 1'b1;
  int          ready_from  = NEVER;
  int          init_end    = NEVER;
  int          ack_cyc     = -1;
  bit          clr_pending = 1'b0;
  int          clr_start   = 0;
  logic [1:0]  clr_thr     = 2'd0;
  bit          prev_drop   = 1'b0;

  function automatic string kname(input int kind);
    case (kind)
      K_RDY:   return "ready";
      K_ACK:   return "clr_ack";
      K_DROP:  return "wr_drop";
      K_RD0:   return "rd_port0";
      default: return "rd_port1";
    endcase
  endfunction

  function automatic logic [15:0] actual(input int kind, input int inst);
    logic [31:0] d;
    d = (inst == 0) ? rdd0 : rdd1;
    case (kind)
      K_RDY:   return 16'((inst == 0) ? rdy0 : rdy1);
      K_ACK:   return 16'((inst == 0) ? ack0 : ack1);
      K_DROP:  return 16'((inst == 0) ? drop0 : drop1);
      K_RD0:   return d[15:0];
      default: return d[31:16];
    endcase
  endfunction

  function automatic void push(input int kind, input int inst, input logic [15:0] v);
    exp_t e;
    e.cyc  = cyc;
    e.kind = kind;
    e.inst = inst;
    e.exp  = v;
    sb.push_back(e);
  endfunction

  // Expected read value in the current cycle.
  function automatic logic [15:0] exp_rd(input logic [4:0] a, input bit zr0, input bit fwd,
                                         input logic [4:0] wa, input logic [15:0] wd);
    logic [15:0] v;
    int          done;
    v = mem[a];
    if (clr_pending && a[4:3] == clr_thr) begin
      done = cyc - clr_start - 1;
      if (int'(a[2:0]) < done) v = 16'h0000;
    end
    if (fwd && a == wa) v = wd;
    if (zr0 && a[2:0] == 3'd0) v = 16'h0000;
    return v;
  endfunction

  task automatic step(input bit rst, input bit we, input logic [4:0] wa, input logic [15:0] wd,
                      input bit clr, input logic [1:0] thr,
                      input logic [4:0] ra0, input logic [4:0] ra1);
    bit rdy;
    @(posedge clk);
    #1;
    reset_n     = rst;
    reg_wr_en   = we;
    wr_reg_addr = wa;
    wr_reg_data = wd;
    clr_req     = clr;
    clr_thread  = thr;
    rd_reg_addr = {ra1, ra0};
    if (!rst) begin
      in_reset    = 1'b1;
      clr_pending = 1'b0;
      ack_cyc     = -1;
      prev_drop   = 1'b0;
      ready_from  = NEVER;
      init_end    = NEVER;
      rdy         = 1'b0;
    end else begin
      if (in_reset) begin
        in_reset   = 1'b0;
        ready_from = cyc + 32;
        init_end   = cyc + 32;
        for (int i = 0; i < 32; i++) mem[i] = 16'h0000;
      end
      if (clr_pending && cyc >= clr_start + 9) begin
        for (int r = 0; r < 8; r++) mem[{clr_thr, 3'(r)}] = 16'h0000;
        clr_pending = 1'b0;
      end
      rdy = (cyc >= ready_from);
    end
    for (int k = 0; k < 2; k++) begin
      push(K_RDY, k, 16'(rdy));
      push(K_ACK, k, 16'(rst && cyc == ack_cyc));
      push(K_DROP, k, 16'(prev_drop));
      if (rst && cyc >= init_end) begin
        push(K_RD0, k, exp_rd(ra0, k == 1, rdy && we, wa, wd));
        push(K_RD1, k, exp_rd(ra1, k == 1, rdy && we, wa, wd));
      end
    end
    prev_drop = rst && we && !rdy;
    if (rst && rdy && we) mem[wa] = wd;
    if (rst && rdy && clr) begin
      clr_pending = 1'b1;
      clr_start   = cyc;
      clr_thr     = thr;
      ready_from  = cyc + 9;
      ack_cyc     = cyc + 9;
    end
  endtask

  task automatic idle(input int n, input logic [4:0] ra0, input logic [4:0] ra1);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 5'd0, 16'h0, 1'b0, 2'd0, ra0, ra1);
  endtask

  task automatic read_all();
    for (int a = 0; a < 16; a++)
      step(1'b1, 1'b0, 5'd0, 16'h0, 1'b0, 2'd0, 5'(a), 5'(a + 16));
  endtask

  // Monitor: compares every expectation due in the current cycle.
  always @(negedge clk) begin
    exp_t        e;
    logic [15:0] act;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e   = sb.pop_front();
      act = actual(e.kind, e.inst);
      total = total + 1;
      if (e.cyc != cyc || act !== e.exp) begin
        bad = bad + 1;
        $display("FAIL %s inst%0d cyc%0d: got %h expected %h",
                 kname(e.kind), e.inst, e.cyc, act, e.exp);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [4:0]  r_wa, r_ra0, r_ra1;
  logic [15:0] r_wd;

  initial begin
    reset_n     = 1'b0;
    reg_wr_en   = 1'b0;
    wr_reg_addr = '0;
    wr_reg_data = '0;
    rd_reg_addr = '0;
    clr_req     = 1'b0;
    clr_thread  = '0;

    // Power-up: reset, 32-cycle init sweep, then everything reads zero.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 5'd0, 16'h0, 1'b0, 2'd0, 5'd0, 5'd0);
    idle(34, 5'd0, 5'd0);
    read_all();

    // Same-cycle forwarding, then stored value.
    step(1'b1, 1'b1, 5'h0A, 16'h1234, 1'b0, 2'd0, 5'h0B, 5'h0A);
    step(1'b1, 1'b0, 5'h00, 16'h0000, 1'b0, 2'd0, 5'h0A, 5'h0B);

    // Fill everything with ones, clear thread 2, attempt a write mid-sweep.
    for (int a = 0; a < 32; a++) step(1'b1, 1'b1, 5'(a), 16'hFFFF, 1'b0, 2'd0, 5'(a), 5'(31 - a));
    step(1'b1, 1'b0, 5'd0, 16'h0, 1'b1, 2'd2, 5'd16, 5'd17);
    step(1'b1, 1'b1, 5'd3, 16'h5555, 1'b0, 2'd0, 5'd16, 5'd3);
    for (int k = 0; k < 9; k++)
      step(1'b1, 1'b0, 5'd0, 16'h0, 1'b0, 2'd0, 5'(16 + (k % 8)), 5'(16 + ((k + 1) % 8)));
    read_all();

    // Write and clear in the same cycle: other thread keeps the write, cleared thread loses it.
    step(1'b1, 1'b1, 5'd4, 16'h4444, 1'b1, 2'd1, 5'd4, 5'd13);
    idle(9, 5'd4, 5'd13);
    step(1'b1, 1'b1, 5'd13, 16'h7777, 1'b1, 2'd1, 5'd13, 5'd4);
    idle(9, 5'd13, 5'd12);

    // Randomized traffic, including clear requests while busy.
    for (int i = 0; i < 300; i++) begin
      r_wa  = 5'($urandom);
      r_wd  = 16'($urandom);
      r_ra0 = 5'($urandom);
      r_ra1 = ($urandom_range(0, 2) == 0) ? r_wa : 5'($urandom);
      step(1'b1, $urandom_range(0, 2) != 0, r_wa, r_wd,
           $urandom_range(0, 15) == 0, 2'($urandom), r_ra0, r_ra1);
    end
    idle(10, 5'd1, 5'd2);
    read_all();

    // Register 0 of a thread: stored, but masked on the zero-r0 instance.
    step(1'b1, 1'b1, 5'd8, 16'hABCD, 1'b0, 2'd0, 5'd8, 5'd9);
    step(1'b1, 1'b0, 5'd0, 16'h0, 1'b0, 2'd0, 5'd8, 5'd9);

    // Reset during a thread clear: no ack, full init afterwards.
    step(1'b1, 1'b0, 5'd0, 16'h0, 1'b1, 2'd1, 5'd8, 5'd9);
    idle(3, 5'd8, 5'd9);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 5'd0, 16'h0, 1'b0, 2'd0, 5'd0, 5'd0);
    idle(34, 5'd0, 5'd0);
    read_all();

    @(negedge clk);
    @(negedge clk);
    total = total + 1;
    if (sb.size() != 0) begin
      bad = bad + 1;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcpu_regfile_mt.md
BCPU_REGFILE_MT -- requirements
Module: bcpu_regfile_mt

Interface
REQ-001 Parameter DATA_WIDTH, 16: register width in bits (16, 17 or 18).
REQ-002 Parameter REG_BITS, 3: log2 of registers per thread.
REQ-003 Parameter THREAD_BITS, 2: log2 of hardware threads.
REQ-004 Parameter RD_PORTS, 2: number of asynchronous read ports (1..4).
REQ-005 Parameter BYPASS, 1: 1 = same-cycle write-to-read forwarding, 0 = none.
REQ-006 Parameter ZERO_R0, 0: 1 = register 0 of every thread always reads 0.
REQ-007 CLK  in  1  single clock; all state changes on its rising edge.
REQ-008 RESET_N  in  1  asynchronous, active-low reset.
REQ-009 REG_WR_EN  in  1  write strobe.
REQ-010 WR_REG_ADDR  in  ADDR_W  write address {thread, reg}; ADDR_W = THREAD_BITS+REG_BITS.
REQ-011 WR_REG_DATA  in  DATA_WIDTH  write data.
REQ-012 RD_REG_ADDR  in  RD_PORTS x ADDR_W  packed read addresses, port i at slice i.
REQ-013 RD_REG_DATA  out  RD_PORTS x DATA_WIDTH  packed read data, port i at slice i.
REQ-014 CLR_REQ  in  1  request to zero all registers of one thread.
REQ-015 CLR_THREAD  in  THREAD_BITS  thread to clear; sampled when CLR_REQ is accepted.
REQ-016 CLR_ACK  out  1  one-cycle pulse: thread clear complete.
REQ-017 READY  out  1  high when in IDLE and accepting writes and clear requests.
REQ-018 WR_DROP  out  1  one-cycle pulse: a REG_WR_EN write was discarded.

Function
REQ-019 Storage: 2^ADDR_W words; writes synchronous; reads combinational, zero-cycle latency.
REQ-020 FSM states: INIT (full sweep), IDLE, TCLR (thread sweep).
REQ-021 INIT: sweep counter starts at 0, writes 0 to one address per cycle, 2^ADDR_W cycles, then IDLE.
REQ-022 IDLE: REG_WR_EN=1 writes WR_REG_DATA to WR_REG_ADDR at the clock edge.
REQ-023 IDLE with CLR_REQ=1: latch CLR_THREAD, enter TCLR next cycle, sweep reg 0..2^REG_BITS-1 of that thread, one per cycle.
REQ-024 TCLR: CLR_ACK pulses in the cycle after the last register is written; FSM returns to IDLE in that same cycle.
REQ-025 READY=1 only in IDLE; CLR_REQ outside IDLE is ignored (requester holds until READY).
REQ-026 REG_WR_EN in INIT or TCLR: write not performed; WR_DROP pulses next cycle.
REQ-027 Same IDLE cycle REG_WR_EN and CLR_REQ: write performed, clear accepted; a write to the cleared thread is overwritten by the sweep.
REQ-028 BYPASS=1, IDLE, REG_WR_EN=1 and RD_REG_ADDR[i]==WR_REG_ADDR: RD_REG_DATA[i]=WR_REG_DATA in that cycle.
REQ-029 BYPASS=0 or write not performed: read returns stored content only.
REQ-030 ZERO_R0=1: reads of reg 0 return 0 regardless of stored content or bypass; writes to reg 0 are still stored.
REQ-031 Reads during INIT/TCLR return current storage content (partially cleared, no forwarding).
REQ-032 Sweep counters wrap-free: terminal count compared explicitly, no modulo reliance.

Reset
REQ-033 RESET_N=0: FSM to INIT, sweep counter 0, READY=0, CLR_ACK=0, WR_DROP=0, latched thread 0.
REQ-034 Storage has no reset; INIT sweep provides zero state.
REQ-035 Reset asserted mid-INIT or mid-TCLR: sweep aborts; full INIT restarts on release; no CLR_ACK for aborted clear.

Structure
REQ-036 Shared package bcpu_regfile_pkg: FSM state enum, ADDR_W derivation function, default parameter constants.
REQ-037 One sub-module bcpu_regfile_ram: storage array, one sync write port, RD_PORTS async read ports; FSM, forwarding and zero-masking stay in the top.
REQ-038 Write-port mux (sweep vs external) lives in the top, feeding the single RAM write port.

Verification
REQ-039 Reset release, defaults (ADDR_W=5): READY=0 for 32 cycles then 1; all 32 addresses read 0.
REQ-040 IDLE, write 0x1234 to addr 0x0A, BYPASS=1, port 1 reads 0x0A same cycle -> 0x1234; next cycle port 0 reads 0x1234.
REQ-041 Fill all regs with 0xFFFF, CLR_REQ thread 2 -> READY low 8 cycles, CLR_ACK pulse once, addrs 16..23 read 0, others 0xFFFF.
REQ-042 REG_WR_EN addr 3 data 0x5555 during TCLR -> WR_DROP pulse next cycle, addr 3 unchanged.
REQ-043 ZERO_R0=1, write 0xABCD to addr 8 -> read addr 8 returns 0, addr 9 unaffected.
REQ-044 RESET_N low at TCLR cycle 4 -> no CLR_ACK; after release full 32-cycle INIT, all reads 0.
